// File: rtl/fifo_umbral_param_if.sv
// Producer/consumer bundle for fifo_umbral_param: requests, data, thresholds and status.
// The FIFO takes the slave side; the producer/consumer side takes master.
interface fifo_umbral_param_if #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned ADDR_WIDTH = 2
);
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] Fifo_Data_in;
  logic [ADDR_WIDTH:0]   umbral_AE;
  logic [ADDR_WIDTH:0]   umbral_AF;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] Fifo_Data_out;
  logic                  Fifo_valid;
  logic [ADDR_WIDTH:0]   Fifo_Count;
  logic                  Fifo_Empty;
  logic                  Fifo_Full;
  logic                  Almost_Empty;
  logic                  Almost_Full;
  logic                  Pausa;
  logic                  Error_Fifo;

  modport master (
    output push, pop, Fifo_Data_in, umbral_AE, umbral_AF, err_clr,
    input  Fifo_Data_out, Fifo_valid, Fifo_Count, Fifo_Empty, Fifo_Full,
           Almost_Empty, Almost_Full, Pausa, Error_Fifo
  );

  modport slave (
    input  push, pop, Fifo_Data_in, umbral_AE, umbral_AF, err_clr,
    output Fifo_Data_out, Fifo_valid, Fifo_Count, Fifo_Empty, Fifo_Full,
           Almost_Empty, Almost_Full, Pausa, Error_Fifo
  );
endinterface

// File: rtl/fifo_umbral_param.sv
// Parametrised synchronous FIFO with programmable almost-empty/almost-full thresholds,
// hysteretic Pausa backpressure, occupancy count, read-valid strobe and sticky error flag.
module fifo_umbral_param #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input logic              clk,
  input logic              reset,
  fifo_umbral_param_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  typedef enum logic [0:0] {StRun, StPause} pausa_state_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  valid_q;
  logic                  empty_q, full_q, almost_empty_q, almost_full_q;
  logic                  err_q, err_d;
  pausa_state_e          state_q;

  logic push_ok, pop_ok, err_set;

  // Acceptance comes from the current occupancy; a full FIFO accepts push only alongside a pop.
  always_comb begin
    pop_ok  = bus.pop && (count_q != '0);
    push_ok = bus.push && ((count_q != CW'(DEPTH)) || pop_ok);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    err_set = (bus.push && !push_ok) || (bus.pop && !pop_ok);
    err_d   = err_q;
    if (err_set) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end
  end

  // Storage is not reset; only pointers and flags are.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= bus.Fifo_Data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      data_out_q     <= '0;
      valid_q        <= 1'b0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (pop_ok) begin
        rd_ptr_q   <= rd_ptr_q + ADDR_WIDTH'(1);
        data_out_q <= mem[rd_ptr_q];
      end
      valid_q        <= pop_ok;
      count_q        <= count_d;
      // Flags decode the next count so they line up with Fifo_Count every cycle.
      empty_q        <= (count_d == '0);
      full_q         <= (count_d == CW'(DEPTH));
      almost_empty_q <= (count_d <= bus.umbral_AE);
      almost_full_q  <= (count_d >= bus.umbral_AF);
      err_q          <= err_d;
    end
  end

  // Pausa hysteresis: enter at the almost-full level, leave only at the almost-empty level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          if (count_d >= bus.umbral_AF) begin
            state_q <= StPause;
          end
        end
        StPause: begin
          if (count_d <= bus.umbral_AE) begin
            state_q <= StRun;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign bus.Fifo_Data_out = data_out_q;
  assign bus.Fifo_valid    = valid_q;
  assign bus.Fifo_Count    = count_q;
  assign bus.Fifo_Empty    = empty_q;
  assign bus.Fifo_Full     = full_q;
  assign bus.Almost_Empty  = almost_empty_q;
  assign bus.Almost_Full   = almost_full_q;
  assign bus.Pausa         = (state_q == StPause);
  assign bus.Error_Fifo    = err_q;

endmodule

// File: tb/tb_fifo_umbral_param.sv
// Directed bench for fifo_umbral_param: a reference occupancy/flag model plus a data
// scoreboard queue, checked with immediate assertions after every clock.
module tb_fifo_umbral_param;
  localparam int unsigned DW    = 6;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AE    = 1;
  localparam int unsigned AF    = 3;

  logic clk = 1'b0;
  logic reset;

  fifo_umbral_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_umbral_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] sb_q[$];
  int            m_count;
  logic          m_err;
  logic          m_pause;
  logic [DW-1:0] m_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_count = 0;
    m_err   = 1'b0;
    m_pause = 1'b0;
    m_last  = '0;
  endtask

  task automatic check_state(input string tag, input logic exp_valid);
    check({tag, ".count"}, 32'(bus.Fifo_Count), 32'(m_count));
    check({tag, ".empty"}, 32'(bus.Fifo_Empty), 32'(m_count == 0));
    check({tag, ".full"}, 32'(bus.Fifo_Full), 32'(m_count == DEPTH));
    check({tag, ".aempty"}, 32'(bus.Almost_Empty), 32'(m_count <= AE));
    check({tag, ".afull"}, 32'(bus.Almost_Full), 32'(m_count >= AF));
    check({tag, ".pausa"}, 32'(bus.Pausa), 32'(m_pause));
    check({tag, ".err"}, 32'(bus.Error_Fifo), 32'(m_err));
    check({tag, ".valid"}, 32'(bus.Fifo_valid), 32'(exp_valid));
    check({tag, ".dout"}, 32'(bus.Fifo_Data_out), 32'(m_last));
  endtask

  // One clock: drive requests, advance the model, sample 1 time unit after the edge.
  task automatic step(input string tag, input logic p, input logic q, input logic [DW-1:0] d,
                      input logic clr);
    logic pop_ok, push_ok;
    bus.push         = p;
    bus.pop          = q;
    bus.Fifo_Data_in = d;
    bus.err_clr      = clr;
    pop_ok  = q && (m_count > 0);
    push_ok = p && ((m_count < DEPTH) || pop_ok);
    if (pop_ok) m_last = sb_q.pop_front();
    if (push_ok) sb_q.push_back(d);
    m_count = m_count + int'(push_ok) - int'(pop_ok);
    if ((p && !push_ok) || (q && !pop_ok)) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    if (!m_pause && m_count >= AF) m_pause = 1'b1;
    else if (m_pause && m_count <= AE) m_pause = 1'b0;
    @(posedge clk);
    #1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.err_clr = 1'b0;
    check_state(tag, pop_ok);
  endtask

  initial begin
    reset            = 1'b1;
    bus.push         = 1'b0;
    bus.pop          = 1'b0;
    bus.err_clr      = 1'b0;
    bus.Fifo_Data_in = '0;
    bus.umbral_AE    = 3'(AE);
    bus.umbral_AF    = 3'(AF);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // 1) reset then idle
    check_state("reset", 1'b0);
    step("idle", 1'b0, 1'b0, '0, 1'b0);

    // 2) fill 1..4
    for (int i = 1; i <= 4; i++) step($sformatf("fill%0d", i), 1'b1, 1'b0, 6'(i), 1'b0);

    // 3) drain, data arrives one cycle after its pop
    for (int i = 1; i <= 4; i++) step($sformatf("drain%0d", i), 1'b0, 1'b1, '0, 1'b0);
    step("hold_dout", 1'b0, 1'b0, '0, 1'b0);

    // 4) overflow on full, then clear
    for (int i = 5; i <= 8; i++) step($sformatf("refill%0d", i), 1'b1, 1'b0, 6'(i), 1'b0);
    step("overflow", 1'b1, 1'b0, 6'h3F, 1'b0);
    step("err_clr", 1'b0, 1'b0, '0, 1'b1);

    // 5) push+pop on full, then drain across the pointer wrap
    step("full_pp", 1'b1, 1'b1, 6'h2A, 1'b0);
    for (int i = 1; i <= 4; i++) step($sformatf("wrap%0d", i), 1'b0, 1'b1, '0, 1'b0);

    // 6) push+pop on empty: push only, underflow flagged
    step("empty_pp", 1'b1, 1'b1, 6'h15, 1'b0);
    step("burst_a", 1'b1, 1'b0, 6'h16, 1'b0);
    step("burst_b", 1'b1, 1'b1, 6'h17, 1'b0);

    // Reset asserted between edges must act without a clock
    bus.push = 1'b1;
    bus.Fifo_Data_in = 6'h18;
    #2;
    reset = 1'b1;
    #1;
    bus.push = 1'b0;
    model_reset();
    check_state("async_rst", 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_state("post_rst", 1'b0);
    step("after_rst_push", 1'b1, 1'b0, 6'h11, 1'b0);
    step("after_rst_pop", 1'b0, 1'b1, '0, 1'b0);
    step("after_rst_under", 1'b0, 1'b1, '0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
